dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 20 ++
 rtl/dmem_responder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Core-side request/response signals of the data-memory responder.
// The shared io_data bus stays a plain inout port on the responder.
interface dmem_responder_if;
  logic        i_memReq;
  logic        i_memWrite;
  logic [31:0] i_addr;
  logic [1:0]  i_size;
  logic        o_ready;
  logic        o_misaligned;

  modport master (
    output i_memReq, i_memWrite, i_addr, i_size,
    input  o_ready, o_misaligned
  );

  modport slave (
    input  i_memReq, i_memWrite, i_addr, i_size,
    output o_ready, o_misaligned
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory: captures one access in IDLE, waits LATENCY cycles, completes in DONE.
// Stores commit on the DONE-entry edge; loads drive the aligned word on io_data only while in DONE.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  dmem_responder_if.slave  bus,
  inout  wire  [31:0]      io_data
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW+1:0] cap_addr;
  logic          cap_write;
  logic [1:0]    cap_size;
  logic [31:0]   cap_data;
  logic          ready_q;
  logic          mis_q;
  logic          drive_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          in_idle;
  logic [AW+1:0] eff_addr;
  logic          eff_write;
  logic [1:0]    eff_size;
  logic [31:0]   eff_data;
  logic [AW-1:0] eff_idx;
  logic          eff_mis;
  logic          finish;
  logic [3:0]    be;
  logic [31:0]   wdata;

  // Address bits above the storage size are deliberately dropped so accesses wrap.
  wire unused_addr = ^bus.i_addr[31:AW+2];

  // With LATENCY=0 the completing edge is the capture edge, so the live inputs are used directly.
  always_comb begin
    in_idle   = (state == IDLE);
    eff_addr  = in_idle ? bus.i_addr[AW+1:0] : cap_addr;
    eff_write = in_idle ? bus.i_memWrite : cap_write;
    eff_size  = in_idle ? bus.i_size : cap_size;
    eff_data  = in_idle ? io_data : cap_data;
    eff_idx   = eff_addr[AW+1:2];
    eff_mis   = ((eff_size == 2'b01) && eff_addr[0]) ||
                (eff_size[1] && (eff_addr[1:0] != 2'b00));
    finish    = (in_idle && bus.i_memReq && (LATENCY == 0)) ||
                ((state == WAIT) && (cnt == 4'd1));
  end

  always_comb begin
    be    = 4'b1111;
    wdata = eff_data;
    case (eff_size)
      2'b00: begin
        be    = 4'b0001 << eff_addr[1:0];
        wdata = {4{eff_data[7:0]}};
      end
      2'b01: begin
        be    = eff_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{eff_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_size  <= 2'b00;
      cap_data  <= 32'd0;
      ready_q   <= 1'b0;
      mis_q     <= 1'b0;
      drive_q   <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      drive_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_memReq) begin
            cap_addr  <= bus.i_addr[AW+1:0];
            cap_write <= bus.i_memWrite;
            cap_size  <= bus.i_size;
            if (bus.i_memWrite) cap_data <= io_data;
            if (LATENCY == 0) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= LAT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (finish) begin
        ready_q <= 1'b1;
        mis_q   <= eff_mis;
        drive_q <= !eff_write;
        rdata_q <= eff_mis ? 32'd0 : mem[eff_idx];
      end
    end
  end

  // Memory has no reset; a reset on the commit edge cancels the store.
  always_ff @(posedge i_clk) begin
    if (!i_reset && finish && eff_write && !eff_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[eff_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_misaligned = mis_q;
  assign io_data          = drive_q ? rdata_q : 32'bz;

endmodule
